mprj_wb_responder: RTL and testbench

- Wishbone classic slave on the user-project side of the exported management bus (the mprj_* master port driven by the management core).
- Decodes a base-address window and holds a small byte-writable word store.
- Returns ack after a programmable number of wait states.
- Serves as the reference responder for firmware bring-up and as the bus endpoint for user designs that need a scratch register bank.

---
 rtl/mprj_wb_pkg.sv | 31 +++
 rtl/mprj_wb_regfile.sv | 81 ++++++++
 rtl/mprj_wb_responder.sv | 144 ++++++++++++++
 tb/tb_mprj_wb_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_wb_pkg.sv
// Shared encodings and widths for the mprj Wishbone responder slice.
// Used by mprj_wb_regfile and mprj_wb_responder.
package mprj_wb_pkg;

  localparam int WB_DW      = 32;
  localparam int WB_SELW    = 4;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_e;

  // Byte-lane merge: lanes with sel=1 take the new byte, others keep the old one.
  function automatic logic [WB_DW-1:0] lane_merge(
    input logic [WB_DW-1:0]   old_word,
    input logic [WB_DW-1:0]   new_word,
    input logic [WB_SELW-1:0] sel
  );
    logic [WB_DW-1:0] merged;
    merged = old_word;
    for (int i = 0; i < WB_SELW; i++) begin
      if (sel[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mprj_wb_regfile.sv
// DEPTH x 32 word store with per-lane writes and a registered read port.
// With MPRJ_WB_DOORBELL_EN defined, the last word also drives a registered doorbell irq.
module mprj_wb_regfile
  import mprj_wb_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_idx,
  input  logic [WB_SELW-1:0] wr_sel,
  input  logic [WB_DW-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_idx,
  output logic [WB_DW-1:0]   rd_data_o,
  output logic               irq_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WB_DW-1:0] mem_q [DEPTH];
  logic [WB_DW-1:0] mem_d [DEPTH];
  logic [WB_DW-1:0] rd_data_q;
  logic [WB_DW-1:0] rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = lane_merge(mem_q[wr_idx], wr_data, wr_sel);
    end
  end

  // The read register is zero whenever no read is being acked.
  always_comb begin
    rd_data_d = '0;
    if (rd_en) begin
      rd_data_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

`ifdef MPRJ_WB_DOORBELL_EN
  logic irq_q;
  logic irq_d;

  // Doorbell follows the merged value committed to the top word.
  always_comb begin
    irq_d = irq_q;
    if (wr_en && (wr_idx == '1)) begin
      irq_d = (mem_d[wr_idx] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: rtl/mprj_wb_responder.sv
// Wishbone classic slave for the mprj management bus: windowed scratch store with programmable wait states.
// Optional doorbell on the top word is enabled by defining MPRJ_WB_DOORBELL_EN.
module mprj_wb_responder
  import mprj_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          ADDR_W      = 6,
  parameter int          WAIT_STATES = 1
) (
  input  logic                core_clk,
  input  logic                core_rstn,
  input  logic                wb_iena_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [WB_SELW-1:0]  wb_sel_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [WB_DW-1:0]    wb_dat_i,
  output logic                wb_ack_o,
  output logic [WB_DW-1:0]    wb_dat_o,
  output logic                irq_o
);

  localparam logic [31:0]           WIN_MASK  = (32'd4 << ADDR_W) - 32'd1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  wb_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [WB_SELW-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [WB_DW-1:0]      dat_q, dat_d;

  logic                  bus_live;
  logic                  hit;
  logic                  req_valid;
  logic                  enter_ack;
  logic                  acc_we;
  logic [WB_SELW-1:0]    acc_sel;
  logic [ADDR_W-1:0]     acc_idx;
  logic [WB_DW-1:0]      acc_dat;
  logic [WB_DW-1:0]      rd_data;
  logic                  irq_raw;
  logic                  unused_adr_lsb;

  assign bus_live       = wb_iena_i & wb_cyc_i & wb_stb_i;
  assign hit            = ((wb_adr_i & ~WIN_MASK) == BASE_ADDR);
  assign req_valid      = bus_live & hit;
  assign unused_adr_lsb = ^wb_adr_i[1:0];

  // acc_* is the request committed on the edge entering ACK; with zero wait
  // states that edge is also the acceptance edge, so the live bus is used.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    dat_d     = dat_q;
    enter_ack = 1'b0;
    acc_we    = we_q;
    acc_sel   = sel_q;
    acc_idx   = idx_q;
    acc_dat   = dat_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d  = wb_we_i;
          sel_d = wb_sel_i;
          idx_d = wb_adr_i[ADDR_W+1:2];
          dat_d = wb_dat_i;
          cnt_d = WAIT_LOAD;
          if (WAIT_STATES == 0) begin
            state_d   = ACK;
            enter_ack = 1'b1;
            acc_we    = wb_we_i;
            acc_sel   = wb_sel_i;
            acc_idx   = wb_adr_i[ADDR_W+1:2];
            acc_dat   = wb_dat_i;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!bus_live) begin
          state_d = IDLE;
        end else if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d   = ACK;
          enter_ack = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      idx_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
    end
  end

  mprj_wb_regfile #(
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (core_clk),
    .rst_n     (core_rstn),
    .wr_en     (enter_ack & acc_we),
    .wr_idx    (acc_idx),
    .wr_sel    (acc_sel),
    .wr_data   (acc_dat),
    .rd_en     (enter_ack & ~acc_we),
    .rd_idx    (acc_idx),
    .rd_data_o (rd_data),
    .irq_o     (irq_raw)
  );

  // A dropped return-path enable silences every output immediately.
  assign wb_ack_o = (state_q == ACK) & wb_iena_i;
  assign wb_dat_o = wb_iena_i ? rd_data : '0;
  assign irq_o    = irq_raw & wb_iena_i;

endmodule

// File: tb/tb_mprj_wb_responder.sv
// Table-driven bench for mprj_wb_responder with a response scoreboard and hand-written corner sequences.
// Doorbell expectations follow MPRJ_WB_DOORBELL_EN.
module tb_mprj_wb_responder;

  localparam int WS        = 1;
  localparam int ACK_BOUND = 20;
  localparam int NVEC      = 14;

  logic        core_clk;
  logic        core_rstn;
  logic        wb_iena_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        irq_o;

  mprj_wb_responder #(
    .BASE_ADDR   (32'h3000_0000),
    .ADDR_W      (6),
    .WAIT_STATES (WS)
  ) dut (
    .core_clk  (core_clk),
    .core_rstn (core_rstn),
    .wb_iena_i (wb_iena_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_sel_i  (wb_sel_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_o  (wb_ack_o),
    .wb_dat_o  (wb_dat_o),
    .irq_o     (irq_o)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        exp_ack;
    logic [31:0] exp_dat;
  } vec_t;

  typedef struct {
    logic        exp_ack;
    logic [31:0] exp_dat;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endfunction

  // Drive a request at a falling edge and record what the responder owes us.
  task automatic apply_stimulus(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                                input logic [31:0] dat, input logic exp_ack, input logic [31:0] exp_dat);
    exp_t e;
    @(negedge core_clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_sel_i = sel;
    wb_adr_i = adr;
    wb_dat_i = dat;
    e.exp_ack = exp_ack;
    e.exp_dat = exp_dat;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for the ack, pop the scoreboard and compare, then release the bus.
  task automatic check_output(input string name);
    exp_t e;
    int   i;
    int   lat;
    bit   seen;
    e    = sb_q.pop_front();
    seen = 1'b0;
    lat  = 0;
    i    = 0;
    while (!seen && i < ACK_BOUND) begin
      @(negedge core_clk);
      i++;
      if (wb_ack_o === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if (e.exp_ack) begin
      compare({name, " ack"}, 32'(seen), 32'd1);
      if (seen) begin
        compare({name, " latency"}, 32'(lat), 32'(WS + 1));
        compare({name, " data"}, wb_dat_o, e.exp_dat);
      end
    end else begin
      compare({name, " no ack"}, 32'(seen), 32'd0);
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    if (seen) begin
      @(negedge core_clk);
      compare({name, " ack one cycle"}, 32'(wb_ack_o), 32'd0);
      compare({name, " data cleared"}, wb_dat_o, 32'd0);
    end
  endtask

  task automatic run_txn(input string name, input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input logic exp_ack, input logic [31:0] exp_dat);
    apply_stimulus(we, sel, adr, dat, exp_ack, exp_dat);
    check_output(name);
  endtask

  initial begin
    bit seen;

    core_rstn = 1'b1;
    wb_iena_i = 1'b1;
    wb_cyc_i  = 1'b0;
    wb_stb_i  = 1'b0;
    wb_we_i   = 1'b0;
    wb_sel_i  = 4'h0;
    wb_adr_i  = 32'h0;
    wb_dat_i  = 32'h0;
    #1 core_rstn = 1'b0;
    repeat (3) @(negedge core_clk);
    compare("reset ack", 32'(wb_ack_o), 32'd0);
    compare("reset dat", wb_dat_o, 32'd0);
    compare("reset irq", 32'(irq_o), 32'd0);
    core_rstn = 1'b1;

    vecs[0]  = '{1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, 4'hF, 32'h3000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 4'hF, 32'h3000_0000, 32'h1122_3344, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 4'h5, 32'h3000_0000, 32'hAABB_CCDD, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 4'hF, 32'h3000_0000, 32'h0,         1'b1, 32'h11BB_33DD};
    vecs[5]  = '{1'b0, 4'hF, 32'h3000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 4'h0, 32'h3000_0020, 32'hCAFE_F00D, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 4'hF, 32'h3000_0020, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{1'b1, 4'hF, 32'h3000_00F8, 32'h1234_5678, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 4'hF, 32'h3000_00F8, 32'h0,         1'b1, 32'h1234_5678};
    vecs[10] = '{1'b0, 4'hF, 32'h3000_0100, 32'h0,         1'b0, 32'h0};
    vecs[11] = '{1'b1, 4'hF, 32'h2000_0010, 32'h0BAD_0BAD, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 4'hF, 32'h3000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[13] = '{1'b0, 4'hF, 32'h3000_0004, 32'h0,         1'b1, 32'h0};

    for (int i = 0; i < NVEC; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].sel, vecs[i].adr,
              vecs[i].dat, vecs[i].exp_ack, vecs[i].exp_dat);
    end

    // Abort: strobe drops while the request is waiting.
    @(negedge core_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF;
    wb_adr_i = 32'h3000_0004; wb_dat_i = 32'h5;
    @(negedge core_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge core_clk);
      if (wb_ack_o === 1'b1) seen = 1'b1;
    end
    compare("abort no ack", 32'(seen), 32'd0);
    run_txn("abort readback", 1'b0, 4'hF, 32'h3000_0004, 32'h0, 1'b1, 32'h0);

    // Request fields changed during WAIT must be ignored.
    @(negedge core_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF;
    wb_adr_i = 32'h3000_0030; wb_dat_i = 32'h77;
    @(negedge core_clk);
    wb_adr_i = 32'h3000_0034; wb_dat_i = 32'h99;
    seen = (wb_ack_o === 1'b1);
    for (int i = 0; i < ACK_BOUND && !seen; i++) begin
      @(negedge core_clk);
      if (wb_ack_o === 1'b1) seen = 1'b1;
    end
    compare("latched write ack", 32'(seen), 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    run_txn("latched addr", 1'b0, 4'hF, 32'h3000_0030, 32'h0, 1'b1, 32'h77);
    run_txn("changed addr", 1'b0, 4'hF, 32'h3000_0034, 32'h0, 1'b1, 32'h0);

    // Return path disabled: valid write is ignored entirely.
    @(negedge core_clk);
    wb_iena_i = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF;
    wb_adr_i = 32'h3000_0008; wb_dat_i = 32'hFFFF_FFFF;
    seen = 1'b0;
    repeat (10) begin
      @(negedge core_clk);
      if (wb_ack_o === 1'b1) seen = 1'b1;
    end
    compare("iena low no ack", 32'(seen), 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_iena_i = 1'b1;
    run_txn("iena low readback", 1'b0, 4'hF, 32'h3000_0008, 32'h0, 1'b1, 32'h0);

    // Return path dropped during ACK: outputs go low, write still lands.
    @(negedge core_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF;
    wb_adr_i = 32'h3000_0014; wb_dat_i = 32'hA5A5_A5A5;
    repeat (WS + 1) @(posedge core_clk);
    #1;
    compare("ack before iena drop", 32'(wb_ack_o), 32'd1);
    wb_iena_i = 1'b0;
    #1;
    compare("ack gated by iena", 32'(wb_ack_o), 32'd0);
    compare("dat gated by iena", wb_dat_o, 32'd0);
    @(negedge core_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_iena_i = 1'b1;
    run_txn("iena drop readback", 1'b0, 4'hF, 32'h3000_0014, 32'h0, 1'b1, 32'hA5A5_A5A5);

    // Top word: doorbell when enabled, plain storage otherwise.
    run_txn("top write 1", 1'b1, 4'hF, 32'h3000_00FC, 32'h1, 1'b1, 32'h0);
`ifdef MPRJ_WB_DOORBELL_EN
    compare("doorbell set", 32'(irq_o), 32'd1);
`else
    compare("irq tied low", 32'(irq_o), 32'd0);
`endif
    run_txn("top readback", 1'b0, 4'hF, 32'h3000_00FC, 32'h0, 1'b1, 32'h1);
    run_txn("top write 0", 1'b1, 4'hF, 32'h3000_00FC, 32'h0, 1'b1, 32'h0);
    compare("doorbell clear", 32'(irq_o), 32'd0);
    run_txn("top write 3", 1'b1, 4'h1, 32'h3000_00FC, 32'h3, 1'b1, 32'h0);
`ifdef MPRJ_WB_DOORBELL_EN
    compare("doorbell reset pre", 32'(irq_o), 32'd1);
`endif

    // Reset pulsed in the middle of WAIT.
    run_txn("pre-reset write", 1'b1, 4'hF, 32'h3000_0018, 32'h1234, 1'b1, 32'h0);
    @(negedge core_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_adr_i = 32'h3000_0018; wb_dat_i = 32'h0;
    @(posedge core_clk);
    #2 core_rstn = 1'b0;
    #1;
    compare("mid-wait reset ack", 32'(wb_ack_o), 32'd0);
    compare("mid-wait reset dat", wb_dat_o, 32'd0);
    compare("mid-wait reset irq", 32'(irq_o), 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge core_clk);
    core_rstn = 1'b1;
    run_txn("reset clears word 0x18", 1'b0, 4'hF, 32'h3000_0018, 32'h0, 1'b1, 32'h0);
    run_txn("reset clears word 0x10", 1'b0, 4'hF, 32'h3000_0010, 32'h0, 1'b1, 32'h0);
    run_txn("reset clears top word", 1'b0, 4'hF, 32'h3000_00FC, 32'h0, 1'b1, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
